// File: rtl/dev_timer_poller.sv
// Purpose: bus initiator that periodically polls a timer device control register, clears it and raises IRQ.
// Latency: one REQ cycle after POLLTICKS wait cycles, then one READ and (if ready) one CLEAR cycle per granted beat.
// Backpressure: holds BUS_REQ until BUS_GNT; a beat that loses its grant is retried without recounting.
module dev_timer_poller #(
  parameter int              DBITS     = 32,
  parameter logic [DBITS-1:0] CTRLADDR = 32'hF0000100,
  parameter int              POLLTICKS = 1000,
  parameter int              CBITS     = 16
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             EN,
  output logic             BUS_REQ,
  input  logic             BUS_GNT,
  output logic [DBITS-1:0] ABUS,
  output logic             WE,
  output logic [DBITS-1:0] DBUS_OUT,
  input  logic [DBITS-1:0] DBUS_IN,
  output logic             IRQ,
  input  logic             IRQ_ACK,
  output logic [CBITS-1:0] EVT_COUNT,
  output logic             OVF
);

  localparam int TBITS = $clog2(POLLTICKS);
  localparam logic [TBITS-1:0] LASTTICK = TBITS'(POLLTICKS - 1);

  typedef enum logic [1:0] {WAIT, REQ, READ, CLEAR} stateT;

  stateT            state, nextState;
  logic             retryClear, nextRetryClear;
  logic [TBITS-1:0] tick, nextTick;
  logic             evtHit;
  logic             unusedDbus;

  // Only the ready and overflow bits of the control register matter here.
  assign unusedDbus = ^DBUS_IN[DBITS-1:2];

  // The only write this block ever issues is a clear, so write data is constant zero.
  assign DBUS_OUT = '0;

  // Next-state logic: wait counter, bus handshake and retry of a beat that lost its grant.
  always_comb begin
    nextState      = state;
    nextRetryClear = retryClear;
    nextTick       = tick;
    evtHit         = 1'b0;
    case (state)
      WAIT: begin
        if (!EN) begin
          nextTick = '0;
        end else if (tick == LASTTICK) begin
          nextTick  = '0;
          nextState = REQ;
        end else begin
          nextTick = tick + TBITS'(1);
        end
      end
      REQ: begin
        if (BUS_GNT) nextState = retryClear ? CLEAR : READ;
      end
      READ: begin
        if (!BUS_GNT) begin
          nextState      = REQ;
          nextRetryClear = 1'b0;
        end else if (DBUS_IN[0]) begin
          nextState = CLEAR;
          evtHit    = 1'b1;
        end else begin
          nextState = WAIT;
        end
      end
      CLEAR: begin
        if (BUS_GNT) begin
          nextState      = WAIT;
          nextRetryClear = 1'b0;
        end else begin
          nextState      = REQ;
          nextRetryClear = 1'b1;
        end
      end
      default: nextState = WAIT;
    endcase
  end

  // State, retry flag and wait counter registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= WAIT;
      retryClear <= 1'b0;
      tick       <= '0;
    end else begin
      state      <= nextState;
      retryClear <= nextRetryClear;
      tick       <= nextTick;
    end
  end

  // Bus outputs registered from next state so they are valid on the cycle the state is entered.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      BUS_REQ <= 1'b0;
      ABUS    <= '0;
      WE      <= 1'b0;
    end else begin
      BUS_REQ <= (nextState != WAIT);
      ABUS    <= (nextState == READ || nextState == CLEAR) ? CTRLADDR : '0;
      WE      <= (nextState == CLEAR);
    end
  end

  // Event counting, level IRQ with acknowledge, sticky overflow on device overflow or lost event.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      EVT_COUNT <= '0;
      IRQ       <= 1'b0;
      OVF       <= 1'b0;
    end else begin
      if (evtHit) begin
        EVT_COUNT <= EVT_COUNT + CBITS'(1);
        IRQ       <= 1'b1;
        if (DBUS_IN[1] || (IRQ && !IRQ_ACK)) OVF <= 1'b1;
      end else if (IRQ_ACK) begin
        IRQ <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dev_timer_poller.sv
// Purpose: randomized check of dev_timer_poller against a transaction-level reference model.
// Latency: model predicts every cycle's outputs; poll period and post-reset first read are timed explicitly.
// Backpressure: BUS_GNT is randomly withheld to exercise request holding and beat retry.
module tb_dev_timer_poller;

  localparam int          DBITS     = 32;
  localparam logic [31:0] CTRLADDR  = 32'hF0000100;
  localparam int          POLLTICKS = 4;
  localparam int          CBITS     = 4;

  logic             CLK = 1'b0;
  logic             RESET_N, EN, BUS_REQ, BUS_GNT, WE, IRQ, IRQ_ACK, OVF;
  logic [DBITS-1:0] ABUS, DBUS_OUT, DBUS_IN;
  logic [CBITS-1:0] EVT_COUNT;
  logic [1:0]       devCtrl;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model: a poll is a sequence of bus beats; a lost grant repeats the pending beat.
  typedef enum {OP_NONE, OP_RD, OP_WR} opT;
  bit         busy, refIrq, refOvf, periodMode;
  opT         curOp, pendOp;
  int         idleRun, lastRead, relCyc;
  logic [CBITS-1:0] refCount;

  always #5 CLK = ~CLK;

  // Timer device: control register visible on reads of its address.
  assign DBUS_IN = (ABUS == CTRLADDR && !WE) ? {30'd0, devCtrl} : '0;

  dev_timer_poller #(
    .DBITS(DBITS), .CTRLADDR(CTRLADDR), .POLLTICKS(POLLTICKS), .CBITS(CBITS)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .EN(EN), .BUS_REQ(BUS_REQ), .BUS_GNT(BUS_GNT),
    .ABUS(ABUS), .WE(WE), .DBUS_OUT(DBUS_OUT), .DBUS_IN(DBUS_IN), .IRQ(IRQ),
    .IRQ_ACK(IRQ_ACK), .EVT_COUNT(EVT_COUNT), .OVF(OVF)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic modelReset();
    busy     = 1'b0;
    curOp    = OP_NONE;
    pendOp   = OP_RD;
    idleRun  = 0;
    refIrq   = 1'b0;
    refOvf   = 1'b0;
    refCount = '0;
    lastRead = -1;
  endtask

  // Called mid-cycle: compare outputs with the model, then advance the model across the next edge.
  task automatic checkAndModel();
    bit evt;
    bit isRead;
    cyc++;
    if (!RESET_N) modelReset();
    checkVal("BUS_REQ", 32'(BUS_REQ), 32'(busy));
    checkVal("ABUS", ABUS, (curOp != OP_NONE) ? CTRLADDR : 32'd0);
    checkVal("WE", 32'(WE), 32'(curOp == OP_WR));
    checkVal("DBUS_OUT", DBUS_OUT, 32'd0);
    checkVal("IRQ", 32'(IRQ), 32'(refIrq));
    checkVal("EVT_COUNT", 32'(EVT_COUNT), 32'(refCount));
    checkVal("OVF", 32'(OVF), 32'(refOvf));
    if (!RESET_N) return;

    isRead = (ABUS == CTRLADDR) && !WE;
    if (isRead && relCyc >= 0) begin
      checkVal("firstRead", 32'(cyc - relCyc), 32'(POLLTICKS + 2));
      relCyc = -1;
    end
    if (isRead && periodMode) begin
      if (lastRead >= 0) checkVal("rdPeriod", 32'(cyc - lastRead), 32'(POLLTICKS + 2));
      lastRead = cyc;
    end

    evt = busy && curOp == OP_RD && BUS_GNT && devCtrl[0];
    if (evt) begin
      if (devCtrl[1] || (refIrq && !IRQ_ACK)) refOvf = 1'b1;
      refIrq   = 1'b1;
      refCount = refCount + 1'b1;
    end else if (IRQ_ACK) begin
      refIrq = 1'b0;
    end

    if (!busy) begin
      if (EN) begin
        idleRun++;
        if (idleRun == POLLTICKS) begin
          busy    = 1'b1;
          idleRun = 0;
          curOp   = OP_NONE;
        end
      end else begin
        idleRun = 0;
      end
    end else if (curOp == OP_NONE) begin
      if (BUS_GNT) curOp = pendOp;
    end else if (!BUS_GNT) begin
      pendOp = curOp;
      curOp  = OP_NONE;
    end else if (curOp == OP_RD) begin
      if (evt) curOp = OP_WR;
      else begin
        busy  = 1'b0;
        curOp = OP_NONE;
      end
    end else begin
      busy   = 1'b0;
      curOp  = OP_NONE;
      pendOp = OP_RD;
    end

    // The device honours the write the poller actually drives.
    if (WE && ABUS == CTRLADDR && BUS_GNT) devCtrl = 2'b00;
  endtask

  task automatic oneCycle(input int gntPct, input int rdyPct, input int ackPct, input int enPct);
    @(posedge CLK);
    #1;
    BUS_GNT = ($urandom_range(99) < gntPct);
    IRQ_ACK = ($urandom_range(99) < ackPct);
    EN      = ($urandom_range(99) < enPct);
    if ($urandom_range(99) < rdyPct) begin
      devCtrl[0] = 1'b1;
      if ($urandom_range(3) == 0) devCtrl[1] = 1'b1;
    end
    @(negedge CLK);
    checkAndModel();
  endtask

  initial begin
    bit found;
    RESET_N = 1'b0; EN = 1'b0; BUS_GNT = 1'b0; IRQ_ACK = 1'b0; devCtrl = 2'b00;
    relCyc = -1; periodMode = 1'b0;
    modelReset();
    repeat (2) begin
      @(negedge CLK);
      checkAndModel();
    end

    // Quiet device, permanent grant: fixed poll period, no writes, no IRQ.
    @(posedge CLK);
    #1 RESET_N = 1'b1; EN = 1'b1; BUS_GNT = 1'b1;
    relCyc = cyc;
    periodMode = 1'b1;
    @(negedge CLK);
    checkAndModel();
    repeat (30) oneCycle(100, 0, 0, 100);
    periodMode = 1'b0;
    checkVal("firstReadSeen", 32'(relCyc == -1), 32'd1);

    // Ready events with full grant, then with a contended bus and EN toggling.
    repeat (600)  oneCycle(100, 30, 10, 100);
    repeat (1500) oneCycle(60, 40, 15, 90);

    // Reset asserted while a clear beat is on the bus.
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      oneCycle(70, 60, 0, 100);
      if (WE) found = 1'b1;
    end
    checkVal("clearSeen", 32'(found), 32'd1);
    #1 RESET_N = 1'b0;
    #1;
    checkVal("rstWE", 32'(WE), 32'd0);
    checkVal("rstBUS_REQ", 32'(BUS_REQ), 32'd0);
    checkVal("rstIRQ", 32'(IRQ), 32'd0);
    checkVal("rstEVT_COUNT", 32'(EVT_COUNT), 32'd0);
    checkVal("rstABUS", ABUS, 32'd0);
    modelReset();
    repeat (2) begin
      @(negedge CLK);
      checkAndModel();
    end
    @(posedge CLK);
    #1 RESET_N = 1'b1; EN = 1'b1; BUS_GNT = 1'b1; IRQ_ACK = 1'b0; devCtrl = 2'b00;
    relCyc = cyc;
    @(negedge CLK);
    checkAndModel();
    repeat (20) oneCycle(100, 0, 0, 100);
    checkVal("postRstReadSeen", 32'(relCyc == -1), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
